// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared types and constants for the RV32 fetch sequencer
package rv32_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_UPDATE,
    S_HALT,
    S_TRAP
  } fetch_state_t;

  localparam logic [1:0] TRAP_NONE     = 2'd0;
  localparam logic [1:0] TRAP_MISALIGN = 2'd1;
  localparam logic [1:0] TRAP_TIMEOUT  = 2'd2;

endpackage

// File: rtl/rv32_fetch_controller_if.sv
// rtl/rv32_fetch_controller_if.sv - PC, instruction-memory and execute signals of the fetch sequencer
interface rv32_fetch_controller_if;
  import rv32_pkg::*;

  logic [XLEN-1:0] pc_value;
  logic [XLEN-1:0] alu_target;
  logic [XLEN-1:0] imm_offset;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic            exec_done;
  logic            is_jal;
  logic            is_jalr;
  logic            branch_taken;
  logic            halt_req;
  logic            pc_en;
  logic            pc_alu_sel;
  logic            pc_next_sel;
  logic            trap;
  logic [1:0]      trap_cause;
  logic            halted;
  logic [XLEN-1:0] instret;

  modport master (
    input  pc_value, alu_target, imm_offset,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  exec_done, is_jal, is_jalr, branch_taken, halt_req,
    output imem_req, imem_addr, instr_valid, instr,
    output pc_en, pc_alu_sel, pc_next_sel,
    output trap, trap_cause, halted, instret
  );

  modport slave (
    output pc_value, alu_target, imm_offset,
    output imem_gnt, imem_rvalid, imem_rdata,
    output exec_done, is_jal, is_jalr, branch_taken, halt_req,
    input  imem_req, imem_addr, instr_valid, instr,
    input  pc_en, pc_alu_sel, pc_next_sel,
    input  trap, trap_cause, halted, instret
  );

endinterface

// File: rtl/rv32_next_pc_decode.sv
// rtl/rv32_next_pc_decode.sv - next-PC select decode and target alignment check
import rv32_pkg::*;

module rv32_next_pc_decode (
  input  logic            i_is_jal,
  input  logic            i_is_jalr,
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_alu_target,
  input  logic [XLEN-1:0] i_imm_offset,
  output logic            o_pc_alu_sel,
  output logic            o_pc_next_sel,
  output logic            o_misaligned
);

  // Only the low target bits matter for the alignment decision.
  logic w_unused_bits;
  assign w_unused_bits = ^{i_alu_target[XLEN-1:2], i_alu_target[0], i_imm_offset[XLEN-1:2]};

  always_comb begin
    o_pc_alu_sel  = 1'b0;
    o_pc_next_sel = 1'b0;
    o_misaligned  = 1'b0;
    if (i_is_jalr) begin
      // JALR clears bit 0 first, so only bit 1 can leave the target misaligned.
      if (i_alu_target[1]) begin
        o_misaligned = 1'b1;
      end else begin
        o_pc_next_sel = 1'b1;
      end
    end else if (i_is_jal || i_branch_taken) begin
      if (i_imm_offset[1:0] != 2'b00) begin
        o_misaligned = 1'b1;
      end else begin
        o_pc_alu_sel = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv32_fetch_controller.sv
// rtl/rv32_fetch_controller.sv - fetch/execute/PC-update sequencer with misalign and timeout traps
import rv32_pkg::*;

module rv32_fetch_controller #(
  parameter int FETCH_TIMEOUT = 16
) (
  input logic                    clk,
  input logic                    reset_n,
  rv32_fetch_controller_if.master bus
);

  // Counter value in the cycle that would make it reach FETCH_TIMEOUT-1.
  localparam logic [7:0] LP_LAST = 8'(FETCH_TIMEOUT - 2);

  fetch_state_t    r_state;
  logic [7:0]      r_cnt;
  logic [XLEN-1:0] r_instr;
  logic            r_instr_valid;
  logic            r_imem_req;
  logic            r_pc_en;
  logic            r_alu_sel;
  logic            r_next_sel;
  logic            r_trap;
  logic [1:0]      r_cause;
  logic            r_halted;
  logic [XLEN-1:0] r_instret;

  logic w_alu_sel;
  logic w_next_sel;
  logic w_misaligned;

  rv32_next_pc_decode u_decode (
    .i_is_jal       (bus.is_jal),
    .i_is_jalr      (bus.is_jalr),
    .i_branch_taken (bus.branch_taken),
    .i_alu_target   (bus.alu_target),
    .i_imm_offset   (bus.imm_offset),
    .o_pc_alu_sel   (w_alu_sel),
    .o_pc_next_sel  (w_next_sel),
    .o_misaligned   (w_misaligned)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
      r_pc_en       <= 1'b0;
      r_alu_sel     <= 1'b0;
      r_next_sel    <= 1'b0;
      r_trap        <= 1'b0;
      r_cause       <= TRAP_NONE;
      r_halted      <= 1'b0;
      r_instret     <= '0;
    end else begin
      // Pulse-style outputs default low; each state re-asserts what it owns.
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_pc_en       <= 1'b0;
      r_alu_sel     <= 1'b0;
      r_next_sel    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (bus.imem_gnt && bus.imem_rvalid) begin
            r_instr       <= bus.imem_rdata;
            r_instr_valid <= 1'b1;
            r_state       <= S_EXEC;
          end else if (bus.imem_gnt) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_imem_req <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            r_instr       <= bus.imem_rdata;
            r_instr_valid <= 1'b1;
            r_state       <= S_EXEC;
          end else if (r_cnt == LP_LAST) begin
            r_trap  <= 1'b1;
            r_cause <= TRAP_TIMEOUT;
            r_state <= S_TRAP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_EXEC: begin
          if (!bus.exec_done) begin
            r_instr_valid <= 1'b1;
          end else if (bus.halt_req) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else if (w_misaligned) begin
            r_trap  <= 1'b1;
            r_cause <= TRAP_MISALIGN;
            r_state <= S_TRAP;
          end else begin
            r_pc_en    <= 1'b1;
            r_alu_sel  <= w_alu_sel;
            r_next_sel <= w_next_sel;
            r_state    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_instret  <= r_instret + 1'b1;
          r_imem_req <= 1'b1;
          r_state    <= S_FETCH;
        end
        S_HALT, S_TRAP: begin
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.imem_req    = r_imem_req;
  assign bus.imem_addr   = r_imem_req ? bus.pc_value : '0;
  assign bus.instr_valid = r_instr_valid;
  assign bus.instr       = r_instr;
  assign bus.pc_en       = r_pc_en;
  assign bus.pc_alu_sel  = r_alu_sel;
  assign bus.pc_next_sel = r_next_sel;
  assign bus.trap        = r_trap;
  assign bus.trap_cause  = r_cause;
  assign bus.halted      = r_halted;
  assign bus.instret     = r_instret;

endmodule

// File: tb/tb_rv32_fetch_controller.sv
// tb/tb_rv32_fetch_controller.sv - scoreboard bench for rv32_fetch_controller
module tb_rv32_fetch_controller;
  import rv32_pkg::*;

  localparam int K_INSTR = 0;
  localparam int K_UPD   = 1;
  localparam int K_TRAP  = 2;
  localparam int K_HALT  = 3;

  typedef struct {
    int          kind;
    logic [31:0] val;
    logic        alu;
    logic        nxt;
    logic [1:0]  cause;
    int          when;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  exp_t sb[$];

  rv32_fetch_controller_if bus();

  rv32_fetch_controller #(.FETCH_TIMEOUT(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int kind, input logic [31:0] val, input logic alu,
                          input logic nxt, input logic [1:0] cause, input int when);
    exp_t e;
    e.kind = kind; e.val = val; e.alu = alu; e.nxt = nxt; e.cause = cause; e.when = when;
    sb.push_back(e);
  endtask

  task automatic pop(input int kind, input string name, output bit ok, output exp_t e);
    ok = 1'b0;
    e.kind = -1; e.val = '0; e.alu = 1'b0; e.nxt = 1'b0; e.cause = '0; e.when = 0;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got an unexpected event, required none (scoreboard empty)", name);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind) begin
        n_fail++;
        $display("FAIL %s: got event kind %0d, required kind %0d", name, kind, e.kind);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  task automatic monitor();
    logic p_iv, p_trap, p_halt;
    int   last_upd;
    exp_t e;
    bit   ok;
    p_iv = 1'b0; p_trap = 1'b0; p_halt = 1'b0; last_upd = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.imem_req) chk("imem_addr", bus.imem_addr, bus.pc_value);
      else              chk("imem_addr_gated", bus.imem_addr, 32'h0);
      if (!bus.pc_en) chk("selects_outside_update", {30'h0, bus.pc_alu_sel, bus.pc_next_sel}, 32'h0);
      if (bus.instr_valid && !p_iv) begin
        pop(K_INSTR, "instr_event", ok, e);
        if (ok) chk("instr", bus.instr, e.val);
      end
      if (bus.pc_en) begin
        pop(K_UPD, "update_event", ok, e);
        if (ok) begin
          chk("pc_alu_sel", {31'h0, bus.pc_alu_sel}, {31'h0, e.alu});
          chk("pc_next_sel", {31'h0, bus.pc_next_sel}, {31'h0, e.nxt});
          chk("instret_in_update", bus.instret, e.val);
          if (e.when != 0) chk("cpi_gap", 32'(cyc - last_upd), 32'(e.when));
        end
        last_upd = cyc;
      end
      if (bus.trap && !p_trap) begin
        pop(K_TRAP, "trap_event", ok, e);
        if (ok) begin
          chk("trap_cause", {30'h0, bus.trap_cause}, {30'h0, e.cause});
          chk("instret_at_trap", bus.instret, e.val);
          if (e.when != 0) chk("trap_cycle", 32'(cyc), 32'(e.when));
        end
      end
      if (bus.halted && !p_halt) begin
        pop(K_HALT, "halt_event", ok, e);
        if (ok) chk("instret_at_halt", bus.instret, e.val);
      end
      p_iv = bus.instr_valid; p_trap = bus.trap; p_halt = bus.halted;
    end
  endtask

  function automatic bit hit(input int sel);
    case (sel)
      0:       return bus.instr_valid;
      1:       return bus.pc_en || bus.trap || bus.halted;
      2:       return bus.imem_req;
      default: return bus.trap;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!hit(sel) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!hit(sel)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got no event within 64 cycles, required one", name);
    end
  endtask

  task automatic clear_inputs();
    bus.pc_value = '0; bus.alu_target = '0; bus.imm_offset = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.exec_done = 1'b0; bus.is_jal = 1'b0; bus.is_jalr = 1'b0;
    bus.branch_taken = 1'b0; bus.halt_req = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    chk("rst_imem_req", {31'h0, bus.imem_req}, 32'h0);
    chk("rst_instr_valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pc_en", {31'h0, bus.pc_en}, 32'h0);
    chk("rst_flags", {28'h0, bus.trap, bus.trap_cause, bus.halted}, 32'h0);
    chk("rst_instret", bus.instret, 32'h0);
    reset_n = 1'b1;
  endtask

  task automatic run_instr(input logic [31:0] rdata, input logic jal, input logic jalr,
                           input logic br, input logic halt, input logic [31:0] tgt,
                           input logic [31:0] imm, input int kind, input logic e_alu,
                           input logic e_nxt, input logic [1:0] e_cause,
                           input logic [31:0] e_instret, input int when,
                           input logic [31:0] next_pc);
    bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b1; bus.imem_rdata = rdata;
    push_exp(K_INSTR, rdata, 1'b0, 1'b0, 2'd0, 0);
    push_exp(kind, e_instret, e_alu, e_nxt, e_cause, when);
    wait_for(0, "wait_exec");
    bus.exec_done = 1'b1; bus.is_jal = jal; bus.is_jalr = jalr;
    bus.branch_taken = br; bus.halt_req = halt; bus.alu_target = tgt; bus.imm_offset = imm;
    wait_for(1, "wait_outcome");
    bus.exec_done = 1'b0; bus.is_jal = 1'b0; bus.is_jalr = 1'b0;
    bus.branch_taken = 1'b0; bus.halt_req = 1'b0;
    if (kind == K_UPD) bus.pc_value = next_pc;
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    fork
      monitor();
    join_none

    // Sequential fetch: ten plain instructions, CPI 3.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_instr(32'h1000_0000 + 32'(i), 0, 0, 0, 0, 0, 0, K_UPD, 0, 0, 2'd0,
                32'(i), (i == 0) ? 0 : 3, 32'(4 * (i + 1)));
    end
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
    @(negedge clk);
    chk("instret_after_10", bus.instret, 32'd10);

    // Control transfers continue from PC 0x28.
    run_instr(32'h0000_0067, 0, 1, 0, 0, 32'hFF00_FF01, 0, K_UPD, 0, 1, 2'd0, 32'd10, 0, 32'hFF00_FF00);
    run_instr(32'h0000_0063, 0, 0, 1, 0, 0, 32'd400, K_UPD, 1, 0, 2'd0, 32'd11, 0, 32'hFF01_0090);
    run_instr(32'h0000_006F, 1, 0, 0, 0, 0, 32'd8, K_UPD, 1, 0, 2'd0, 32'd12, 0, 32'hFF01_0098);
    run_instr(32'h0000_00E7, 1, 1, 0, 0, 32'h0000_0100, 32'd2, K_UPD, 0, 1, 2'd0, 32'd13, 0, 32'h0000_0100);
    run_instr(32'h0000_0163, 0, 0, 1, 0, 0, 32'd402, K_TRAP, 0, 0, 2'd1, 32'd14, 0, 0);
    repeat (3) @(negedge clk);
    chk("branch_trap_sticky", {31'h0, bus.trap}, 32'h1);
    chk("branch_trap_no_req", {31'h0, bus.imem_req}, 32'h0);
    chk("branch_trap_instret", bus.instret, 32'd14);
    chk("sb_drained_1", 32'(sb.size()), 32'h0);

    // Misaligned JALR target.
    do_reset();
    run_instr(32'h0000_0267, 0, 1, 0, 0, 32'hFF00_FF02, 0, K_TRAP, 0, 0, 2'd1, 32'd0, 0, 0);
    repeat (3) @(negedge clk);
    chk("jalr_trap_cause", {30'h0, bus.trap_cause}, 32'h1);
    chk("sb_drained_2", 32'(sb.size()), 32'h0);

    // Halt outranks JAL.
    do_reset();
    run_instr(32'h2000_0001, 0, 0, 0, 0, 0, 0, K_UPD, 0, 0, 2'd0, 32'd0, 0, 32'd4);
    run_instr(32'h2000_0002, 0, 0, 0, 0, 0, 0, K_UPD, 0, 0, 2'd0, 32'd1, 3, 32'd8);
    run_instr(32'h2000_0003, 1, 0, 0, 1, 0, 32'd8, K_HALT, 0, 0, 2'd0, 32'd2, 0, 0);
    repeat (3) @(negedge clk);
    chk("halted_sticky", {31'h0, bus.halted}, 32'h1);
    chk("halt_no_req", {31'h0, bus.imem_req}, 32'h0);
    chk("halt_instret", bus.instret, 32'd2);
    chk("halt_no_trap", {31'h0, bus.trap}, 32'h0);
    chk("sb_drained_3", 32'(sb.size()), 32'h0);

    // Fetch timeout: trap 16 cycles after the grant.
    do_reset();
    wait_for(2, "wait_fetch_to");
    bus.imem_gnt = 1'b1;
    push_exp(K_TRAP, 32'd0, 1'b0, 1'b0, 2'd2, cyc + 16);
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    wait_for(3, "wait_timeout");
    chk("sb_drained_4", 32'(sb.size()), 32'h0);

    // rvalid on the 15th cycle after the grant still completes normally.
    do_reset();
    wait_for(2, "wait_fetch_late");
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    repeat (14) @(negedge clk);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h3000_0015;
    push_exp(K_INSTR, 32'h3000_0015, 1'b0, 1'b0, 2'd0, 0);
    push_exp(K_UPD, 32'd0, 1'b0, 1'b0, 2'd0, 0);
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    chk("late_rvalid_no_trap", {31'h0, bus.trap}, 32'h0);
    chk("late_rvalid_exec", {31'h0, bus.instr_valid}, 32'h1);
    bus.exec_done = 1'b1;
    wait_for(1, "wait_late_update");
    bus.exec_done = 1'b0;
    chk("sb_drained_5", 32'(sb.size()), 32'h0);

    // Reset mid-WAIT; rvalid while IDLE is dropped.
    do_reset();
    wait_for(2, "wait_fetch_rst");
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    chk("idle_no_req", {31'h0, bus.imem_req}, 32'h0);
    chk("idle_no_instr", {31'h0, bus.instr_valid}, 32'h0);
    @(negedge clk);
    chk("req_after_idle", {31'h0, bus.imem_req}, 32'h1);
    chk("rvalid_ignored", {31'h0, bus.instr_valid}, 32'h0);
    @(negedge clk);
    chk("rvalid_alone_in_fetch", {31'h0, bus.instr_valid}, 32'h0);
    bus.imem_rvalid = 1'b0;
    run_instr(32'h4000_0001, 0, 0, 0, 0, 0, 0, K_UPD, 0, 0, 2'd0, 32'd0, 0, 32'd4);
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
    @(negedge clk);
    chk("instret_after_recovery", bus.instret, 32'd1);
    chk("sb_drained_6", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
